switch_input_port: RTL and testbench

- Memory-mapped input peripheral on the CPU data bus. It is the read-side counterpart of the LED/seven-segment output register.
- Synchronises and debounces the board switches and holds the stable value for CPU reads.
- Records per-bit change events in a write-1-to-clear pending register and raises a maskable interrupt request toward the interrupt controller.
- Top level uses `hit` to steer read data and to suppress RAM writes at its addresses.

---
 rtl/switch_input_port_if.sv | 32 +++
 rtl/switch_input_port.sv | 115 +++++++++++
 tb/tb_switch_input_port.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/switch_input_port_if.sv
// switch_input_port_if
//   CPU data-bus connection for the switch input peripheral.
//   master : CPU side. Drives addr, wr_en and wr_data, and receives rd_data and hit.
//   slave  : peripheral side. Decodes the address and returns rd_data and hit.
//   addr    - 16-bit CPU data address
//   wr_en   - CPU write strobe
//   wr_data - 16-bit CPU write data
//   rd_data - read data, combinational from addr
//   hit     - addr is one of this peripheral's registers
interface switch_input_port_if;
    logic [15:0] addr;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        hit;

    modport master (
        output addr,
        output wr_en,
        output wr_data,
        input  rd_data,
        input  hit
    );

    modport slave (
        input  addr,
        input  wr_en,
        input  wr_data,
        output rd_data,
        output hit
    );
endinterface

// File: rtl/switch_input_port.sv
// switch_input_port
//   Memory-mapped switch input peripheral. Raw switch pins are synchronised
//   and then debounced bit by bit, and the stable value is held for CPU reads.
//   Every accepted edge, rising or falling, sets a write-1-to-clear pending flag.
//   A registered, maskable interrupt request goes to the interrupt controller.
//   clk      - system clock
//   reset    - synchronous, active-high reset
//   switches - raw asynchronous switch pins (WIDTH bits)
//   bus      - CPU data bus (slave modport): addr, wr_en, wr_data, rd_data, hit
//   irq      - level interrupt request, |(pending & mask) registered
module switch_input_port #(
    parameter int          WIDTH           = 8,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [15:0] DATA_ADDR       = 16'hCFFD,
    parameter logic [15:0] STATUS_ADDR     = 16'hCFFF,
    parameter logic [15:0] MASK_ADDR       = 16'hD000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    switches,
    switch_input_port_if.slave  bus,
    output logic                irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt    [WIDTH];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] clear;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // A bit is accepted on the edge where it has disagreed with stable for the
    // full debounce window. Clear requests come from STATUS writes. The cast to
    // WIDTH bits drops the upper write-data bits, which have no register behind them.
    always_comb begin
        accept = '0;
        clear  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sync_out[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
        if (bus.wr_en && bus.addr == STATUS_ADDR) begin
            clear = WIDTH'(bus.wr_data);
        end
    end

    // Register decode. Reads have no side effects.
    always_comb begin
        bus.hit     = 1'b0;
        bus.rd_data = '0;
        case (bus.addr)
            DATA_ADDR: begin
                bus.hit     = 1'b1;
                bus.rd_data = 16'(stable);
            end
            STATUS_ADDR: begin
                bus.hit     = 1'b1;
                bus.rd_data = 16'(pending);
            end
            MASK_ADDR: begin
                bus.hit     = 1'b1;
                bus.rd_data = 16'(mask);
            end
            default: begin
                bus.hit     = 1'b0;
                bus.rd_data = '0;
            end
        endcase
    end

    // irq is computed from the pre-edge pending and mask, so it lags them by
    // one edge. A fresh accept ORs in after the clear, so a set wins a same-cycle race.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            stable  <= '0;
            pending <= '0;
            mask    <= '0;
            irq     <= 1'b0;
        end else begin
            sync_q[0] <= switches;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_out[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= sync_out[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
            pending <= (pending & ~clear) | accept;
            if (bus.wr_en && bus.addr == MASK_ADDR) begin
                mask <= WIDTH'(bus.wr_data);
            end
            irq <= |(pending & mask);
        end
    end

endmodule

// File: tb/tb_switch_input_port.sv
// tb_switch_input_port
//   Self-checking bench for switch_input_port. The stimulus process drives the
//   pins and the bus once per cycle. It pushes the expected rd_data, hit and
//   irq into a queue, which a behavioural model computes. An independent
//   monitor pops one entry each negative clock edge and compares it with the DUT.
module tb_switch_input_port;

    localparam int          WIDTH    = 8;
    localparam int          SYNC     = 2;
    localparam int          DEB      = 16;
    localparam logic [15:0] A_DATA   = 16'hCFFD;
    localparam logic [15:0] A_STATUS = 16'hCFFF;
    localparam logic [15:0] A_MASK   = 16'hD000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] switches = '0;
    logic             irq;

    switch_input_port_if bus ();

    switch_input_port #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .DATA_ADDR(A_DATA), .STATUS_ADDR(A_STATUS), .MASK_ADDR(A_MASK)
    ) dut (
        .clk(clk), .reset(reset), .switches(switches), .bus(bus), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rd;
        logic        hit;
        logic        irq;
        logic [15:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // Behavioural model state. The delay line holds the last SYNC pin samples,
    // and run[i] counts the edges bit i has spent disagreeing with stable.
    logic [WIDTH-1:0] m_hist[$];
    int               m_run[WIDTH];
    logic [WIDTH-1:0] m_stable, m_pending, m_mask;
    logic             m_irq;
    bit               m_known = 0;

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (a == A_DATA)   return {8'h00, m_stable};
        if (a == A_STATUS) return {8'h00, m_pending};
        if (a == A_MASK)   return {8'h00, m_mask};
        return 16'h0000;
    endfunction

    function automatic bit model_accepts_next(input int b);
        logic [WIDTH-1:0] so;
        so = m_hist[SYNC-1];
        return (so[b] != m_stable[b]) && (m_run[b] == DEB - 1);
    endfunction

    task automatic model_step(input logic [WIDTH-1:0] sw, input logic [15:0] a,
                              input logic we, input logic [15:0] wd, input logic rst);
        logic [WIDTH-1:0] so, setb, clr;
        if (rst) begin
            m_hist.delete();
            for (int s = 0; s < SYNC; s++) m_hist.push_back('0);
            for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
            m_stable = '0; m_pending = '0; m_mask = '0; m_irq = 1'b0;
            m_known = 1;
            return;
        end
        so   = m_hist[SYNC-1];
        setb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (so[i] == m_stable[i]) m_run[i] = 0;
            else if (m_run[i] == DEB - 1) begin
                setb[i] = 1'b1;
                m_run[i] = 0;
            end else m_run[i] = m_run[i] + 1;
        end
        m_irq      = |(m_pending & m_mask);
        m_stable   = m_stable ^ setb;
        clr        = (we && a == A_STATUS) ? wd[WIDTH-1:0] : '0;
        m_pending  = (m_pending & ~clr) | setb;
        if (we && a == A_MASK) m_mask = wd[WIDTH-1:0];
        m_hist.push_front(sw);
        void'(m_hist.pop_back());
    endtask

    // Drive one cycle of stimulus, push what the DUT must show during it,
    // then advance the model across the coming edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] sw, input logic [15:0] a,
                                 input logic we, input logic [15:0] wd, input logic rst);
        exp_t e;
        @(posedge clk);
        #1;
        switches    = sw;
        bus.addr    = a;
        bus.wr_en   = we;
        bus.wr_data = wd;
        reset       = rst;
        if (m_known) begin
            e.rd = model_read(a); e.hit = (a == A_DATA || a == A_STATUS || a == A_MASK);
            e.irq = m_irq; e.addr = a;
            exp_q.push_back(e);
        end
        model_step(sw, a, we, wd, rst);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] addr,
                               input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s addr=%h at %0t: actual=%h required=%h", name, addr, $time, act, req);
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("rd_data", e.addr, bus.rd_data, e.rd);
                checkOutput("hit", e.addr, {15'b0, bus.hit}, {15'b0, e.hit});
                checkOutput("irq", e.addr, {15'b0, irq}, {15'b0, e.irq});
            end
        end
    end

    // Directed scenarios first, then a randomized run.
    initial begin
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] drv;
        logic [15:0]      a;
        int               tries;
        bus.addr = A_DATA; bus.wr_en = 1'b0; bus.wr_data = '0;

        // Reset while the switches are all high.
        for (int i = 0; i < 3; i++) applyStimulus(8'hFF, A_DATA, 1'b0, 16'h0, 1'b1);
        applyStimulus(8'hFF, A_STATUS, 1'b0, 16'h0, 1'b0);
        applyStimulus(8'hFF, A_MASK, 1'b0, 16'h0, 1'b0);
        applyStimulus(8'h00, A_DATA, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(8'h00, A_DATA, 1'b0, 16'h0, 1'b0);

        // Debounce latency for 0 -> 05.
        for (int i = 0; i < 22; i++) applyStimulus(8'h05, A_DATA, 1'b0, 16'h0, 1'b0);
        applyStimulus(8'h05, A_STATUS, 1'b0, 16'h0, 1'b0);

        // Glitch rejection on bit 3: 15 cycles, then 16 cycles.
        for (int i = 0; i < 15; i++) applyStimulus(8'h0D, A_DATA, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(8'h05, (i % 2) ? A_STATUS : A_DATA, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(8'h0D, A_DATA, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 22; i++) applyStimulus(8'h05, (i % 2) ? A_STATUS : A_DATA, 1'b0, 16'h0, 1'b0);

        // W1C and the set-wins race on bit 2.
        applyStimulus(8'h05, A_STATUS, 1'b1, 16'h0008, 1'b0);
        applyStimulus(8'h05, A_STATUS, 1'b1, 16'h0001, 1'b0);
        applyStimulus(8'h05, A_STATUS, 1'b0, 16'h0, 1'b0);
        tries = 0;
        while (!model_accepts_next(2) && tries < 60) begin
            applyStimulus(8'h01, A_STATUS, 1'b0, 16'h0, 1'b0);
            tries++;
        end
        checkOutput("race_arranged", 16'h0, 16'(tries < 60), 16'h0001);
        applyStimulus(8'h01, A_STATUS, 1'b1, 16'h0004, 1'b0);
        applyStimulus(8'h01, A_STATUS, 1'b0, 16'h0, 1'b0);

        // Interrupt masking.
        for (int i = 0; i < 2; i++) applyStimulus(8'h01, A_STATUS, 1'b0, 16'h0, 1'b0);
        applyStimulus(8'h01, A_MASK, 1'b1, 16'h0004, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(8'h01, A_MASK, 1'b0, 16'h0, 1'b0);
        applyStimulus(8'h01, A_STATUS, 1'b1, 16'h0004, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(8'h01, A_STATUS, 1'b0, 16'h0, 1'b0);

        // Decode holes and a write to the read-only data register.
        applyStimulus(8'h01, 16'hCFFE, 1'b0, 16'h0, 1'b0);
        applyStimulus(8'h01, 16'h1234, 1'b1, 16'hFFFF, 1'b0);
        applyStimulus(8'h01, A_DATA, 1'b1, 16'hFFFF, 1'b0);
        applyStimulus(8'h01, A_DATA, 1'b0, 16'h0, 1'b0);

        // Randomized run: slow switch changes, short glitches, random bus traffic.
        cur = 8'h01;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 29) == 0) cur[$urandom_range(0, WIDTH-1)] ^= 1'b1;
            drv = cur;
            if ($urandom_range(0, 19) == 0) drv[$urandom_range(0, WIDTH-1)] ^= 1'b1;
            case ($urandom_range(0, 6))
                0: a = A_DATA;
                1, 2: a = A_STATUS;
                3: a = A_MASK;
                4: a = 16'hCFFE;
                5: a = 16'hD001;
                default: a = 16'($urandom);
            endcase
            applyStimulus(drv, a, ($urandom_range(0, 3) == 0), 16'($urandom),
                          ($urandom_range(0, 499) == 0));
        end

        @(negedge clk);
        #1;
        checkOutput("queue_drained", 16'h0, 16'(exp_q.size()), 16'h0000);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
